bank_req_arbiter: RTL and testbench
===================================

Name: bank_req_arbiter

Overview:
- Per-bank request scheduler. Shares one bank hit-test unit (HTU) request port between the three channel request streams that target that bank.
- Sits between the cross-bar routing logic and the bank wrapper. One instance per bank (4 total).
- Arbitrates round-robin among ch0..ch2 and registers the winner in a one-entry output stage.
- Output stage drives the bank's valid/ready/ch_id/opcode/addr/wbuffer_id interface.

Parameters:
- ADDR_W, 28, request line-address width (addr[31:4]).
- WBID_W, 8, write-buffer id width.
- OP_W, 2, HTU opcode width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- ch0_valid_i  input  1  channel 0 request valid (already routed to this bank).
- ch0_ready_o  output  1  channel 0 request accepted this cycle.
- ch0_opcode_i  input  OP_W  channel 0 opcode.
- ch0_addr_i  input  ADDR_W  channel 0 address.
- ch0_wbuffer_id_i  input  WBID_W  channel 0 write-buffer id.
- ch1_valid_i / ch1_ready_o / ch1_opcode_i / ch1_addr_i / ch1_wbuffer_id_i  same as ch0, for channel 1.
- ch2_valid_i / ch2_ready_o / ch2_opcode_i / ch2_addr_i / ch2_wbuffer_id_i  same as ch0, for channel 2.
- htu_valid_o  output  1  registered request valid to the bank HTU.
- htu_ready_i  input  1  HTU accepts the request.
- htu_ch_id_o  output  2  originating channel (0..2).
- htu_opcode_o  output  OP_W  registered opcode.
- htu_addr_o  output  ADDR_W  registered address.
- htu_wbuffer_id_o  output  WBID_W  registered write-buffer id.
- arb_busy_o  output  1  any channel valid, or output stage occupied.

Behaviour:
- Clock and reset: clk_i is the single clock. rst_i is asynchronous, active-high.
- Values during and after reset:
  - htu_valid_o=0, htu_ch_id_o=0, htu_opcode_o=0, htu_addr_o=0, htu_wbuffer_id_o=0.
  - rr_ptr=0.
  - All chN_ready_o=0 while rst_i=1.
- Output stage occupancy:
  - Stage is free when htu_valid_o==0 || htu_ready_i==1 (combinational; pop and push may occur in the same cycle).
- Round-robin pointer:
  - rr_ptr is 2 bits, legal values 0,1,2.
  - Priority order is rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3.
  - Value 3 is unreachable. If it is ever observed, treat it as 0.
- Grant (combinational):
  - grant = first valid channel in priority order, and only when the stage is free.
  - chN_ready_o = grant[N]. At most one ready is high per cycle (one-hot or zero).
- On grant to channel k (registered):
  - htu_valid_o<=1, htu_ch_id_o<=k, and payload registered from channel k.
  - rr_ptr<=(k+1) mod 3.
- Stage free, no channel valid:
  - htu_valid_o<=0.
  - Payload registers hold their values (no toggling).
- Backpressure (htu_valid_o=1 and htu_ready_i=0):
  - All outputs hold stable.
  - No ready is asserted.
  - rr_ptr unchanged.
- Latency and throughput:
  - 1 cycle from input acceptance to htu_valid_o.
  - Sustained throughput is 1 request/cycle when htu_ready_i is held high.
- Fairness: with all three channels continuously valid and no backpressure, grants rotate 0,1,2,0,... No channel waits more than 2 grants.
- Upstream rule: an input request must stay stable until its ready is seen. The arbiter does not check this; it is an assertion-only property.
- Reset mid-operation: the in-flight output entry is dropped and htu_valid_o falls asynchronously. Upstream must reissue.
- arb_busy_o = |{ch0_valid_i, ch1_valid_i, ch2_valid_i} | htu_valid_o. This output is combinational.

Test Plan:
- Reset: assert rst_i mid-cycle with htu_valid_o=1 -> htu_valid_o=0 immediately, all readys=0, after release rr_ptr=0.
- Single channel: ch1 valid, addr=0xABCDEF1, wbid=0x5A, htu_ready_i=1 -> ch1_ready_o=1 in cycle 0; cycle 1 shows htu_valid_o=1, ch_id=1, addr=0xABCDEF1, wbid=0x5A.
- All three valid continuously, htu_ready_i=1 for 6 cycles -> htu_ch_id_o sequence 0,1,2,0,1,2, one entry per cycle.
- Backpressure: entry held with htu_ready_i=0 for 4 cycles while ch0/ch2 valid -> outputs stable, no readys. htu_ready_i=1 -> next grant is issued in the same cycle as the pop.
- Pointer wrap: last grant ch2, then only ch1 and ch0 valid -> ch0 granted first, then ch1.
- Idle: no valids after a pop -> htu_valid_o=0 next cycle, payload unchanged, arb_busy_o=0.

Source files
------------

// File: rtl/bank_req_arbiter.sv
// Per-bank round-robin scheduler: picks one of three channel request streams
// and registers it into a single-entry stage that feeds the bank HTU port.
module bank_req_arbiter #(
  parameter int ADDR_W = 28,
  parameter int WBID_W = 8,
  parameter int OP_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ch0_valid_i,
  output logic              ch0_ready_o,
  input  logic [OP_W-1:0]   ch0_opcode_i,
  input  logic [ADDR_W-1:0] ch0_addr_i,
  input  logic [WBID_W-1:0] ch0_wbuffer_id_i,
  input  logic              ch1_valid_i,
  output logic              ch1_ready_o,
  input  logic [OP_W-1:0]   ch1_opcode_i,
  input  logic [ADDR_W-1:0] ch1_addr_i,
  input  logic [WBID_W-1:0] ch1_wbuffer_id_i,
  input  logic              ch2_valid_i,
  output logic              ch2_ready_o,
  input  logic [OP_W-1:0]   ch2_opcode_i,
  input  logic [ADDR_W-1:0] ch2_addr_i,
  input  logic [WBID_W-1:0] ch2_wbuffer_id_i,
  output logic              htu_valid_o,
  input  logic              htu_ready_i,
  output logic [1:0]        htu_ch_id_o,
  output logic [OP_W-1:0]   htu_opcode_o,
  output logic [ADDR_W-1:0] htu_addr_o,
  output logic [WBID_W-1:0] htu_wbuffer_id_o,
  output logic              arb_busy_o
);

  localparam int NCH = 3;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [WBID_W-1:0] wbid;
  } req_t;

  logic [NCH-1:0]         ch_vld;
  req_t [NCH-1:0]         ch_req;
  logic [NCH-1:0]         grant;

  logic                   vld_q, vld_d;
  logic [1:0]             ch_q, ch_d;
  req_t                   req_q, req_d;
  logic [1:0]             ptr_q, ptr_d;

  logic                   stage_free;
  logic                   found;
  logic [1:0]             ptr_eff, idx, gnt_id;

  assign ch_vld    = {ch2_valid_i, ch1_valid_i, ch0_valid_i};
  assign ch_req[0] = {ch0_opcode_i, ch0_addr_i, ch0_wbuffer_id_i};
  assign ch_req[1] = {ch1_opcode_i, ch1_addr_i, ch1_wbuffer_id_i};
  assign ch_req[2] = {ch2_opcode_i, ch2_addr_i, ch2_wbuffer_id_i};

  // Pop and push can share a cycle, so the stage counts as free while draining.
  assign stage_free = !vld_q || htu_ready_i;

  always_comb begin
    ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
    idx     = ptr_eff;
    gnt_id  = ptr_eff;
    found   = 1'b0;
    grant   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && ch_vld[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    if (found && stage_free) grant[gnt_id] = 1'b1;
  end

  always_comb begin
    vld_d = vld_q;
    ch_d  = ch_q;
    req_d = req_q;
    ptr_d = ptr_q;
    if (found && stage_free) begin
      vld_d = 1'b1;
      ch_d  = gnt_id;
      req_d = ch_req[gnt_id];
      ptr_d = (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
    end else if (stage_free) begin
      // Payload is left alone when idle to avoid needless toggling.
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      ch_q  <= '0;
      req_q <= '0;
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      ch_q  <= ch_d;
      req_q <= req_d;
      ptr_q <= ptr_d;
    end
  end

  assign ch0_ready_o      = grant[0] & ~rst_i;
  assign ch1_ready_o      = grant[1] & ~rst_i;
  assign ch2_ready_o      = grant[2] & ~rst_i;

  assign htu_valid_o      = vld_q;
  assign htu_ch_id_o      = ch_q;
  assign htu_opcode_o     = req_q.op;
  assign htu_addr_o       = req_q.addr;
  assign htu_wbuffer_id_o = req_q.wbid;

  assign arb_busy_o       = (|ch_vld) | vld_q;

endmodule

// File: tb/tb_bank_req_arbiter.sv
// Bench for bank_req_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level round-robin model.
module tb_bank_req_arbiter;

  localparam int AW = 28;
  localparam int WW = 8;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    v;
  logic [OW-1:0] op [3];
  logic [AW-1:0] ad [3];
  logic [WW-1:0] wb [3];
  logic          hr;
  logic          r0, r1, r2;
  logic [2:0]    rdy;
  logic          htu_v;
  logic [1:0]    htu_ch;
  logic [OW-1:0] htu_op;
  logic [AW-1:0] htu_ad;
  logic [WW-1:0] htu_wb;
  logic          busy;

  assign rdy = {r2, r1, r0};

  always #5 clk = ~clk;

  bank_req_arbiter #(.ADDR_W(AW), .WBID_W(WW), .OP_W(OW)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch0_valid_i(v[0]), .ch0_ready_o(r0), .ch0_opcode_i(op[0]),
    .ch0_addr_i(ad[0]), .ch0_wbuffer_id_i(wb[0]),
    .ch1_valid_i(v[1]), .ch1_ready_o(r1), .ch1_opcode_i(op[1]),
    .ch1_addr_i(ad[1]), .ch1_wbuffer_id_i(wb[1]),
    .ch2_valid_i(v[2]), .ch2_ready_o(r2), .ch2_opcode_i(op[2]),
    .ch2_addr_i(ad[2]), .ch2_wbuffer_id_i(wb[2]),
    .htu_valid_o(htu_v), .htu_ready_i(hr), .htu_ch_id_o(htu_ch),
    .htu_opcode_o(htu_op), .htu_addr_o(htu_ad), .htu_wbuffer_id_o(htu_wb),
    .arb_busy_o(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one held entry plus a round-robin pointer.
  int            m_ptr, m_ch, last_g;
  bit            m_v;
  logic [OW-1:0] m_op;
  logic [AW-1:0] m_ad;
  logic [WW-1:0] m_wb;
  logic [AW-1:0] snap_ad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_ch = 0; m_op = '0; m_ad = '0; m_wb = '0; m_ptr = 0; last_g = -1;
  endtask

  function automatic int exp_grant();
    if (m_v && !hr) return -1;
    for (int j = 0; j < 3; j++)
      if (v[(m_ptr + j) % 3]) return (m_ptr + j) % 3;
    return -1;
  endfunction

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle(input string tag);
    int g;
    logic [2:0] er;
    #1;
    g  = exp_grant();
    er = (g < 0) ? 3'b000 : 3'(1 << g);
    chk({tag, "_rdy"},  64'(rdy),    64'(er));
    chk({tag, "_vld"},  64'(htu_v),  64'(m_v));
    chk({tag, "_ch"},   64'(htu_ch), 64'(m_ch));
    chk({tag, "_op"},   64'(htu_op), 64'(m_op));
    chk({tag, "_addr"}, 64'(htu_ad), 64'(m_ad));
    chk({tag, "_wbid"}, 64'(htu_wb), 64'(m_wb));
    chk({tag, "_busy"}, 64'(busy),   64'((v != 3'b000) || m_v));
    @(posedge clk);
    if (g >= 0) begin
      m_v = 1; m_ch = g; m_op = op[g]; m_ad = ad[g]; m_wb = wb[g];
      m_ptr = (g + 1) % 3;
    end else if (!m_v || hr) begin
      m_v = 0;
    end
    last_g = g;
    @(negedge clk);
  endtask

  task automatic new_payload(input int k);
    op[k] = OW'($urandom);
    ad[k] = AW'($urandom);
    wb[k] = WW'($urandom);
  endtask

  initial begin
    v = '0; hr = 1'b0;
    for (int k = 0; k < 3; k++) begin op[k] = '0; ad[k] = '0; wb[k] = '0; end
    model_reset();

    // Reset values, with requests present
    @(negedge clk);
    v = 3'b111;
    #1;
    chk("rst_rdy",  64'(rdy),    64'(0));
    chk("rst_vld",  64'(htu_v),  64'(0));
    chk("rst_addr", 64'(htu_ad), 64'(0));
    chk("rst_ch",   64'(htu_ch), 64'(0));
    @(negedge clk);
    rst = 1'b0; v = '0;

    // Single channel request
    v = 3'b010; ad[1] = 28'hABCDEF1; wb[1] = 8'h5A; op[1] = 2'd1; hr = 1'b1;
    cycle("sc0");
    v = 3'b000;
    #1;
    chk("sc_vld",  64'(htu_v),  64'(1));
    chk("sc_ch",   64'(htu_ch), 64'(1));
    chk("sc_addr", 64'(htu_ad), 64'(28'hABCDEF1));
    chk("sc_wbid", 64'(htu_wb), 64'(8'h5A));

    // Mid-cycle reset with an entry held
    v = 3'b111; hr = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mrst_vld", 64'(htu_v), 64'(0));
    chk("mrst_rdy", 64'(rdy),   64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // All channels streaming, no backpressure: 0,1,2,0,1,2
    v = 3'b111; hr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle("rr");
      if (i < 6) begin
        #1 chk("rr_seq", 64'(htu_ch), 64'(i % 3));
      end
      if (last_g >= 0) new_payload(last_g);
    end

    // Backpressure: entry held, no readys
    v = 3'b101; hr = 1'b0;
    snap_ad = htu_ad;
    for (int i = 0; i < 4; i++) cycle("bp");
    chk("bp_hold_addr", 64'(htu_ad), 64'(snap_ad));
    chk("bp_hold_vld",  64'(htu_v),  64'(1));
    hr = 1'b1;
    #1 chk("bp_pop_rdy", 64'(rdy), 64'(3'b100));
    cycle("bp_pop");

    // Pointer wrap after a ch2 grant
    v = 3'b011;
    #1 chk("wrap0", 64'(rdy), 64'(3'b001));
    cycle("wrap0");
    v = 3'b010;
    #1 chk("wrap1", 64'(rdy), 64'(3'b010));
    cycle("wrap1");

    // Idle after a pop
    v = 3'b000;
    cycle("idle0");
    cycle("idle1");
    #1;
    chk("idle_vld",  64'(htu_v),  64'(0));
    chk("idle_busy", 64'(busy),   64'(0));
    chk("idle_addr", 64'(htu_ad), 64'(ad[1]));

    // Randomized traffic; a request stays stable until it is accepted
    @(negedge clk);
    last_g = -1;
    for (int n = 0; n < 600; n++) begin
      hr = ($urandom % 4) != 0;
      for (int k = 0; k < 3; k++) begin
        if (!v[k] || last_g == k) begin
          v[k] = 1'($urandom % 2);
          new_payload(k);
        end
      end
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
